// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the fetch/data SRAM arbiter.
// The optional starvation guard is enabled with SRAM_ARB_STARVE_GUARD_EN.
package sram_arbiter_pkg;

  // Port whose access is in flight, so that the response goes back to it.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_owner_t;

  localparam logic [3:0]  SRAM_BEN_IDLE  = 4'hF;
  localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

  // Width of a counter that must be able to hold the value limit.
  function automatic int unsigned starve_cnt_w(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the two core memory ports and the SRAM macro pins.
// The arbiter takes the slave view; the core and SRAM side take the master view.
interface sram_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        sram_cen;
  logic        sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output sram_cen, sram_wen, sram_ben, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  sram_cen, sram_wen, sram_ben, sram_addr, sram_din,
    output sram_dout
  );

endinterface

// File: rtl/sram_arb_starve.sv
// Fetch starvation counter: asserts o_force_if once a pending fetch has lost
// STARVE_LIMIT consecutive cycles to data. Used only with SRAM_ARB_STARVE_GUARD_EN.
module sram_arb_starve
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  input  logic i_d_gnt,
  output logic o_force_if
);

  localparam int unsigned CW = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_V = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_q;
  logic [CW-1:0] w_starve_next;

  always_comb begin
    w_starve_next = r_starve_q;
    if (!i_if_req || i_if_gnt) begin
      w_starve_next = '0;
    end else if (i_d_gnt && (r_starve_q != LIMIT_V)) begin
      // Saturate so a misbehaving requester cannot wrap the counter.
      w_starve_next = r_starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_q <= '0;
    end else begin
      r_starve_q <= w_starve_next;
    end
  end

  assign o_force_if = (r_starve_q == LIMIT_V);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store, data first.
// Define SRAM_ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT losses.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  rsp_owner_t  r_rsp_q;
  rsp_owner_t  w_rsp_next;
  logic        r_run;
  logic        w_active;
  logic        w_force_if;
  logic        w_d_win;
  logic        w_if_win;
  logic        w_cen;
  logic        w_wen;
  logic [3:0]  w_ben;
  logic [31:0] w_addr;
  logic [31:0] w_din;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  sram_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_req   (bus.if_req),
    .i_if_gnt   (w_if_win),
    .i_d_gnt    (w_d_win),
    .o_force_if (w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif

  // Grants need reset low-free now and sampled high at the previous edge.
  assign w_active = rst_n & r_run;

  always_comb begin
    w_d_win    = w_active & bus.d_req & ~(w_force_if & bus.if_req);
    w_if_win   = w_active & bus.if_req & ~w_d_win;
    w_cen      = 1'b1;
    w_wen      = 1'b1;
    w_ben      = SRAM_BEN_IDLE;
    w_addr     = '0;
    w_din      = '0;
    w_rsp_next = RSP_NONE;
    if (w_d_win) begin
      w_cen      = 1'b0;
      w_wen      = ~bus.d_we;
      w_ben      = ~bus.d_be;
      w_addr     = bus.d_addr & ADDR_WORD_MASK;
      w_din      = bus.d_wdata;
      w_rsp_next = RSP_D;
    end else if (w_if_win) begin
      w_cen      = 1'b0;
      w_wen      = 1'b1;
      w_ben      = 4'h0;
      w_addr     = bus.if_addr & ADDR_WORD_MASK;
      w_din      = bus.d_wdata;
      w_rsp_next = RSP_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_q <= RSP_NONE;
      r_run   <= 1'b0;
    end else begin
      r_rsp_q <= w_rsp_next;
      r_run   <= 1'b1;
    end
  end

  assign bus.if_gnt    = w_if_win;
  assign bus.d_gnt     = w_d_win;
  assign bus.sram_cen  = w_cen;
  assign bus.sram_wen  = w_wen;
  assign bus.sram_ben  = w_ben;
  assign bus.sram_addr = w_addr;
  assign bus.sram_din  = w_din;

  // The SRAM registers its output, so the owner captured last cycle qualifies it.
  assign bus.if_rvalid = rst_n & (r_rsp_q == RSP_IF);
  assign bus.d_rvalid  = rst_n & (r_rsp_q == RSP_D);
  assign bus.if_rdata  = bus.sram_dout;
  assign bus.d_rdata   = bus.sram_dout;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port, one-cycle-latency data SRAM between the RV32E instruction-fetch port and the load/store port. It issues at most one SRAM access per cycle and routes each read response back to the port that issued it. It sits between the core's two memory ports and the `sram_*` macro pins.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: maximum number of consecutive cycles in which a pending fetch can lose to data. Used only with `SRAM_ARB_STARVE_GUARD_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `if_req`  in  1  fetch request (read-only).
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  32  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables, active-high.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid, or store acknowledge.
- `d_rdata`  out  32  load data.
- `sram_cen`  out  1  chip enable, active-low.
- `sram_wen`  out  1  write enable, active-low.
- `sram_ben`  out  4  byte enables, active-low.
- `sram_addr`  out  32  byte address; bits [1:0] are forced to 0.
- `sram_din`  out  32  write data.
- `sram_dout`  in  32  read data, registered by the SRAM, valid 1 cycle after the access.

## Operation
- Grant is combinational in the request cycle, and at most one grant is issued per cycle.
- Default priority: data over fetch. If both requests are high, `d_gnt`=1 and `if_gnt`=0.
- On a grant, the SRAM pins are driven from the winner in the same cycle:
  - `sram_cen`=0.
  - `sram_wen`=~`d_we` for data; 1 for fetch.
  - `sram_ben`=~`d_be` for data; 4'h0 for fetch.
  - `sram_din`=`d_wdata`.
- With no grant, the pins idle at: `sram_cen`=1, `sram_wen`=1, `sram_ben`=4'hF, `sram_addr`=0, `sram_din`=0.
- Response-owner register `rsp_q` ∈ {RSP_NONE, RSP_IF, RSP_D} is loaded each cycle with the granted port.
- In the next cycle:
  - `if_rvalid`=(`rsp_q`==RSP_IF).
  - `d_rvalid`=(`rsp_q`==RSP_D).
  - Both `if_rdata` and `d_rdata` are driven combinationally from `sram_dout`. Each is meaningful only while its `rvalid` is high.
  - A store also produces `d_rvalid`; `d_rdata` is don't-care for a store.
- Back-to-back grants are allowed; throughput is 1 access per cycle.
- A requester keeps its request and payload stable until it sees `gnt`. A request that loses arbitration simply retries in the next cycle.
- Bytes with `d_be`=0 are left untouched. `d_be`=4'h0 with `d_we`=1 is still granted: the access is a no-op write with `sram_ben`=4'hF.
- Reset (`rst_n`=0 at an edge):
  - `rsp_q`←RSP_NONE and the starvation counter←0.
  - While `rst_n` is low, `if_gnt`, `d_gnt` and both `rvalid` outputs are forced to 0, and the SRAM pins are held idle.
  - Reset during an access drops any in-flight response; no `rvalid` follows.

## Timing
- Cycle N: request high → `gnt`=1 and SRAM pins driven in cycle N.
- Cycle N+1: `rvalid`=1 with data.
- Load-use latency is 1 cycle.
- First possible grant is in the first cycle after `rst_n` is sampled high.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined:
  - A counter `starve_q` increments on each cycle where `if_req`=1 and `d_gnt`=1. It clears on any `if_gnt` or when `if_req`=0.
  - When `starve_q`==`STARVE_LIMIT`, fetch wins the next contested cycle, then the counter clears.
  - Counter width is $clog2(`STARVE_LIMIT`+1).
- Not defined: strict data priority; the counter logic is absent.

## Structure
- Add `rsp_owner_t` (RSP_NONE/RSP_IF/RSP_D) to the shared `types` package.
- One sub-module, `sram_arb_starve`, holds the starvation counter and emits the `force_if` signal. It is instantiated only under the macro.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with both requests high → all `gnt`/`rvalid`=0, `sram_cen`=1, `sram_ben`=4'hF.
- Fetch only: `if_req` at 0x8, with word 2 = 0x00000013 → `if_gnt` in the same cycle; next cycle `if_rvalid`=1, `if_rdata`=0x00000013.
- Byte store then load: store 0xAABBCCDD to 0x100 with `d_be`=4'hF, store 0x11 with `d_be`=4'b0001, then load 0x100 → `sram_ben`=4'hE on the second store; load returns 0xAABBCC11 one cycle after its grant.
- Contention: `if_req`=`d_req`=1 for one cycle → `d_gnt`=1, `if_gnt`=0; fetch granted in the following cycle. Responses arrive in the same order, with no cross-routing of `rvalid`.
- Starvation, macro on, `STARVE_LIMIT`=4, both requests held high continuously → data wins for 4 cycles, fetch wins the 5th, and the pattern repeats. Macro off → fetch is never granted.
- Reset mid-access: load granted in cycle N, `rst_n`=0 sampled at the end of cycle N → no `d_rvalid` in cycle N+1.
